// File: rtl/ram_responder.sv
// 256x8 RAM with CPU read/write handshake and a sequential program loader.
// Optional MEM_PARITY_EN adds a per-byte even-parity bit and the parity_err output.
module ram_responder (
    input  logic       clk,
    input  logic       reset,
    // "program" is a reserved word in SystemVerilog, so the mode select is prog_mode
    input  logic       prog_mode,
    input  logic       prog_valid,
    input  logic [7:0] prog_data,
    input  logic       en_mar,
    input  logic [7:0] mar_in,
    input  logic       en_mem,
    input  logic       rw_mem,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       mem_ready,
    output logic [7:0] prog_addr,
    output logic       prog_wrap
`ifdef MEM_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, PROG} state_t;

    state_t     state, next_state;
    logic [7:0] mar;
    logic [7:0] mem [256];
    logic [7:0] acc_addr;
    logic       accept, cpu_we, prog_we, done, rd_done;

    always_comb begin
        next_state = state;
        if (prog_mode) begin
            next_state = PROG;
        end else begin
            case (state)
                IDLE:    if (en_mem) next_state = rw_mem ? READ : WRITE;
                READ:    next_state = IDLE;
                WRITE:   next_state = IDLE;
                PROG:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // A same-edge MAR load forwards mar_in to the access being accepted.
    assign acc_addr = en_mar ? mar_in : mar;
    assign accept   = (state == IDLE) && !prog_mode && en_mem;
    assign cpu_we   = accept && !rw_mem && !reset;
    assign prog_we  = (state == PROG) && prog_mode && prog_valid && !reset;
    // Entering PROG out of READ/WRITE aborts the completion pulse.
    assign done     = ((state == READ) || (state == WRITE)) && !prog_mode;
    assign rd_done  = done && (state == READ);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mar       <= 8'h00;
            rd_data   <= 8'h00;
            mem_ready <= 1'b0;
            prog_addr <= 8'h00;
            prog_wrap <= 1'b0;
        end else begin
            state     <= next_state;
            mem_ready <= done;
            if (en_mar)  mar     <= mar_in;
            if (rd_done) rd_data <= mem[mar];
            if (prog_we) begin
                prog_addr <= prog_addr + 8'd1;
                if (prog_addr == 8'hFF) prog_wrap <= 1'b1;
            end
        end
    end

    // Memory array is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (cpu_we)       mem[acc_addr]  <= wr_data;
        else if (prog_we) mem[prog_addr] <= prog_data;
    end

`ifdef MEM_PARITY_EN
    logic mem_par [256];

    always_ff @(posedge clk) begin
        if (cpu_we)       mem_par[acc_addr]  <= ^wr_data;
        else if (prog_we) mem_par[prog_addr] <= ^prog_data;
    end

    always_ff @(posedge clk) begin
        if (reset) parity_err <= 1'b0;
        else       parity_err <= rd_done && ((^mem[mar]) != mem_par[mar]);
    end
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: stimulus pushes expected rd_data per access,
// a negedge monitor pops and compares on every mem_ready pulse.
module tb_ram_responder;

    logic       clk, reset, prog_mode, prog_valid, en_mar, en_mem, rw_mem;
    logic [7:0] prog_data, mar_in, wr_data, rd_data, prog_addr;
    logic       mem_ready, prog_wrap;
`ifdef MEM_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    logic [8:0] exp_q [$];   // {expected parity_err, expected rd_data}

    ram_responder dut (
        .clk(clk), .reset(reset), .prog_mode(prog_mode), .prog_valid(prog_valid),
        .prog_data(prog_data), .en_mar(en_mar), .mar_in(mar_in), .en_mem(en_mem),
        .rw_mem(rw_mem), .wr_data(wr_data), .rd_data(rd_data), .mem_ready(mem_ready),
        .prog_addr(prog_addr), .prog_wrap(prog_wrap)
`ifdef MEM_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (mem_ready) begin
            logic [8:0] e;
            pulses++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ready got rd_data=%h, none expected", rd_data);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e[7:0]) begin
                    bad++;
                    $display("FAIL ready_rd_data got %h want %h", rd_data, e[7:0]);
                end
`ifdef MEM_PARITY_EN
                total++;
                if (parity_err !== e[8]) begin
                    bad++;
                    $display("FAIL parity_err got %b want %b", parity_err, e[8]);
                end
`endif
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cpu();
        en_mar = 0; en_mem = 0; rw_mem = 0; mar_in = 0; wr_data = 0;
    endtask

    // Accept edge, completion edge, then one spare edge so the monitor samples.
    task automatic cpu_access(input logic [7:0] addr, input logic rd,
                              input logic [7:0] wd, input logic [8:0] exp);
        exp_q.push_back(exp);
        en_mar = 1; mar_in = addr; en_mem = 1; rw_mem = rd; wr_data = wd;
        tick();
        clear_cpu();
        tick();
        tick();
    endtask

    task automatic load_byte(input logic [7:0] b);
        prog_valid = 1; prog_data = b;
        tick();
        prog_valid = 0;
    endtask

    function automatic logic [7:0] wrap_byte(input int i);
        logic [7:0] b;
        b = (i == 256) ? 8'hC3 : 8'((i * 7 + 1) & 255);
        return b;
    endfunction

    initial begin
        int p0;
        logic [7:0] init_bytes [4];
        init_bytes = '{8'h3E, 8'h05, 8'h80, 8'h76};
        reset = 1; prog_mode = 0; prog_valid = 0; prog_data = 0;
        clear_cpu();
        tick(); tick();
        reset = 0;
        check("reset_rd_data",   rd_data,   8'h00);
        check("reset_mem_ready", mem_ready, 1'b0);
        check("reset_prog_addr", prog_addr, 8'h00);
        check("reset_prog_wrap", prog_wrap, 1'b0);

        // Load four bytes.
        prog_mode = 1; tick();
        for (int i = 0; i < 4; i++) load_byte(init_bytes[i]);
        check("load4_prog_addr", prog_addr, 8'h04);
        check("load4_prog_wrap", prog_wrap, 1'b0);
        prog_mode = 0; tick();

        // Same-edge MAR load and read.
        cpu_access(8'h02, 1, 8'h00, {1'b0, 8'h80});
        cpu_access(8'h00, 1, 8'h00, {1'b0, 8'h3E});
        cpu_access(8'h01, 1, 8'h00, {1'b0, 8'h05});
        cpu_access(8'h03, 1, 8'h00, {1'b0, 8'h76});
        check("prog_addr_held", prog_addr, 8'h04);

        // Write leaves rd_data at the last read value, then read back.
        cpu_access(8'h10, 0, 8'hA5, {1'b0, 8'h76});
        check("after_write_rd_data", rd_data, 8'h76);
        cpu_access(8'h10, 1, 8'h00, {1'b0, 8'hA5});

        // en_mem held into READ as a write must be ignored.
        exp_q.push_back({1'b0, 8'hA5});
        en_mar = 1; mar_in = 8'h10; en_mem = 1; rw_mem = 1;
        tick();
        en_mar = 0; rw_mem = 0; wr_data = 8'hFF;
        tick();
        clear_cpu();
        tick();
        cpu_access(8'h10, 1, 8'h00, {1'b0, 8'hA5});
        check("pulse_count_a", pulses, 8);

        // Entering PROG in READ aborts without a pulse.
        p0 = pulses;
        en_mar = 1; mar_in = 8'h00; en_mem = 1; rw_mem = 1;
        tick();
        clear_cpu(); prog_mode = 1;
        tick(); tick();
        prog_mode = 0;
        tick(); tick();
        check("abort_no_pulse", pulses, p0);
        check("abort_rd_data",  rd_data, 8'hA5);

        // Reset right after read acceptance drops the access.
        en_mar = 1; mar_in = 8'h01; en_mem = 1; rw_mem = 1;
        tick();
        clear_cpu(); reset = 1;
        tick();
        reset = 0;
        tick(); tick();
        check("reset_abort_no_pulse", pulses, p0);
        check("reset_abort_rd_data",  rd_data, 8'h00);
        check("reset_abort_prog_addr", prog_addr, 8'h00);
        cpu_access(8'h00, 1, 8'h00, {1'b0, 8'h3E});
        cpu_access(8'h03, 1, 8'h00, {1'b0, 8'h76});
        cpu_access(8'h10, 1, 8'h00, {1'b0, 8'hA5});

        // 257-byte load wraps the loader address.
        prog_mode = 1; tick();
        for (int i = 0; i < 257; i++) begin
            load_byte(wrap_byte(i));
            if (i == 254) check("no_wrap_before_255", prog_wrap, 1'b0);
        end
        check("wrap_flag",      prog_wrap, 1'b1);
        check("wrap_prog_addr", prog_addr, 8'h01);
        prog_mode = 0; tick();
        cpu_access(8'h00, 1, 8'h00, {1'b0, 8'hC3});
        cpu_access(8'hC8, 1, 8'h00, {1'b0, 8'h79});
        cpu_access(8'hFF, 1, 8'h00, {1'b0, 8'hFA});
        check("wrap_sticky", prog_wrap, 1'b1);

`ifdef MEM_PARITY_EN
        dut.mem_par[8'hC8] = ~dut.mem_par[8'hC8];
        cpu_access(8'hC8, 1, 8'h00, {1'b1, 8'h79});
        cpu_access(8'h00, 1, 8'h00, {1'b0, 8'hC3});
`endif

        tick(); tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
